// File: rtl/lsb_param.sv
// Parametrised load/store buffer: in-order queue between Dispatcher and LSCtrl with CDB wakeup.
// Optional feature macro: LSB_DISPATCH_BYPASS_EN (same-cycle CDB capture at dispatch).
module lsb_param #(
    parameter int DEPTH      = 16,
    parameter int PTR_W      = 4,
    parameter int CDB_N      = 2,
    parameter int FULL_SLACK = 2,
    parameter int OP_WIDTH   = 6,
    parameter int ROB_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter logic [OP_WIDTH-1:0] OP_LB  = 6'd10,
    parameter logic [OP_WIDTH-1:0] OP_LHU = 6'd14
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        rdy_dp_in,
    input  logic [OP_WIDTH-1:0]         opcode_dp_in,
    input  logic [ROB_WIDTH-1:0]        qj_dp_in,
    input  logic [ROB_WIDTH-1:0]        qk_dp_in,
    input  logic [DATA_WIDTH-1:0]       vj_dp_in,
    input  logic [DATA_WIDTH-1:0]       vk_dp_in,
    input  logic [DATA_WIDTH-1:0]       A_dp_in,
    input  logic [ROB_WIDTH-1:0]        rob_id_dp_in,
    output logic                        lsb_full_dp_out,
    output logic [PTR_W:0]              lsb_count_out,
    input  logic [ROB_WIDTH-1:0]        head_id_rob_in,
    input  logic                        idle_lsc_in,
    output logic                        rdy_lsc_out,
    output logic [OP_WIDTH-1:0]         opcode_lsc_out,
    output logic [DATA_WIDTH-1:0]       vj_lsc_out,
    output logic [DATA_WIDTH-1:0]       vk_lsc_out,
    output logic [DATA_WIDTH-1:0]       imm_lsc_out,
    output logic [ROB_WIDTH-1:0]        rob_id_lsc_out,
    input  logic [CDB_N-1:0]            cdb_rdy_in,
    input  logic [CDB_N*DATA_WIDTH-1:0] cdb_result_in,
    input  logic [CDB_N*ROB_WIDTH-1:0]  cdb_rob_id_in,
    input  logic                        refresh_rob_cdb_in
);

    localparam logic [PTR_W:0] DEPTH_LEVEL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL  = (PTR_W+1)'(DEPTH - FULL_SLACK);

    // Pointers carry a wrap bit so a full buffer differs from an empty one.
    logic [PTR_W:0]          head_r;
    logic [PTR_W:0]          tail_r;
    logic [PTR_W:0]          count_s;
    logic [PTR_W-1:0]        head_idx_s;
    logic [PTR_W-1:0]        tail_idx_s;
    logic                    issue_block_r;

    logic [OP_WIDTH-1:0]     op_r  [DEPTH];
    logic [ROB_WIDTH-1:0]    rob_r [DEPTH];
    logic [DATA_WIDTH-1:0]   imm_r [DEPTH];
    logic [ROB_WIDTH-1:0]    qj_r  [DEPTH];
    logic [ROB_WIDTH-1:0]    qk_r  [DEPTH];
    logic [DATA_WIDTH-1:0]   vj_r  [DEPTH];
    logic [DATA_WIDTH-1:0]   vk_r  [DEPTH];
    logic [ROB_WIDTH-1:0]    qj_s  [DEPTH];
    logic [ROB_WIDTH-1:0]    qk_s  [DEPTH];
    logic [DATA_WIDTH-1:0]   vj_s  [DEPTH];
    logic [DATA_WIDTH-1:0]   vk_s  [DEPTH];

    logic [DEPTH-1:0]        valid_s;
    logic                    dispatch_s;
    logic                    head_load_s;
    logic                    issue_s;
    logic [ROB_WIDTH-1:0]    dp_qj_s;
    logic [ROB_WIDTH-1:0]    dp_qk_s;
    logic [DATA_WIDTH-1:0]   dp_vj_s;
    logic [DATA_WIDTH-1:0]   dp_vk_s;

    assign head_idx_s      = head_r[PTR_W-1:0];
    assign tail_idx_s      = tail_r[PTR_W-1:0];
    assign count_s         = tail_r - head_r;
    assign lsb_count_out   = count_s;
    assign lsb_full_dp_out = (count_s >= FULL_LEVEL);

    // Dispatch acceptance, head classification and issue eligibility.
    always_comb begin
        dispatch_s  = rdy_dp_in && (count_s < DEPTH_LEVEL);
        head_load_s = (op_r[head_idx_s] >= OP_LB) && (op_r[head_idx_s] <= OP_LHU);
        issue_s     = idle_lsc_in && !issue_block_r && (count_s != '0) &&
                      (qj_r[head_idx_s] == '0) && (qk_r[head_idx_s] == '0) &&
                      (head_load_s || (rob_r[head_idx_s] == head_id_rob_in));
        for (int i = 0; i < DEPTH; i++) begin
            valid_s[i] = ({1'b0, PTR_W'(i) - head_idx_s} < count_s);
        end
    end

    // Operand values written at dispatch, optionally captured from a same-cycle broadcast.
    always_comb begin
        dp_qj_s = qj_dp_in;
        dp_qk_s = qk_dp_in;
        dp_vj_s = vj_dp_in;
        dp_vk_s = vk_dp_in;
`ifdef LSB_DISPATCH_BYPASS_EN
        for (int k = 0; k < CDB_N; k++) begin
            if (cdb_rdy_in[k] && (qj_dp_in != '0) &&
                (cdb_rob_id_in[k*ROB_WIDTH +: ROB_WIDTH] == qj_dp_in)) begin
                dp_qj_s = '0;
                dp_vj_s = cdb_result_in[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                dp_qj_s = dp_qj_s;
            end
            if (cdb_rdy_in[k] && (qk_dp_in != '0) &&
                (cdb_rob_id_in[k*ROB_WIDTH +: ROB_WIDTH] == qk_dp_in)) begin
                dp_qk_s = '0;
                dp_vk_s = cdb_result_in[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                dp_qk_s = dp_qk_s;
            end
        end
`endif
    end

    // Next operand state: CDB wakeup on valid entries (highest channel wins), then dispatch write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            qj_s[i] = qj_r[i];
            qk_s[i] = qk_r[i];
            vj_s[i] = vj_r[i];
            vk_s[i] = vk_r[i];
            for (int k = 0; k < CDB_N; k++) begin
                if (valid_s[i] && cdb_rdy_in[k] && (qj_r[i] != '0) &&
                    (cdb_rob_id_in[k*ROB_WIDTH +: ROB_WIDTH] == qj_r[i])) begin
                    qj_s[i] = '0;
                    vj_s[i] = cdb_result_in[k*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    qj_s[i] = qj_s[i];
                end
                if (valid_s[i] && cdb_rdy_in[k] && (qk_r[i] != '0) &&
                    (cdb_rob_id_in[k*ROB_WIDTH +: ROB_WIDTH] == qk_r[i])) begin
                    qk_s[i] = '0;
                    vk_s[i] = cdb_result_in[k*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    qk_s[i] = qk_s[i];
                end
            end
            if (dispatch_s && (PTR_W'(i) == tail_idx_s)) begin
                qj_s[i] = dp_qj_s;
                qk_s[i] = dp_qk_s;
                vj_s[i] = dp_vj_s;
                vk_s[i] = dp_vk_s;
            end else begin
                qj_s[i] = qj_s[i];
            end
        end
    end

    // Entry storage; untouched during reset, flush or freeze.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !refresh_rob_cdb_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                qj_r[i] <= qj_s[i];
                qk_r[i] <= qk_s[i];
                vj_r[i] <= vj_s[i];
                vk_r[i] <= vk_s[i];
            end
            if (dispatch_s) begin
                op_r[tail_idx_s]  <= opcode_dp_in;
                rob_r[tail_idx_s] <= rob_id_dp_in;
                imm_r[tail_idx_s] <= A_dp_in;
            end
        end
    end

    // Queue pointers, issue gap and registered issue port.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_r        <= '0;
            tail_r        <= '0;
            issue_block_r <= 1'b0;
            rdy_lsc_out   <= 1'b0;
        end else if (rdy_in) begin
            if (refresh_rob_cdb_in) begin
                head_r        <= '0;
                tail_r        <= '0;
                issue_block_r <= 1'b0;
                rdy_lsc_out   <= 1'b0;
            end else begin
                if (dispatch_s) begin
                    tail_r <= tail_r + (PTR_W+1)'(1);
                end
                if (issue_s) begin
                    head_r         <= head_r + (PTR_W+1)'(1);
                    opcode_lsc_out <= op_r[head_idx_s];
                    vj_lsc_out     <= vj_r[head_idx_s];
                    vk_lsc_out     <= vk_r[head_idx_s];
                    imm_lsc_out    <= imm_r[head_idx_s];
                    rob_id_lsc_out <= rob_r[head_idx_s];
                end
                rdy_lsc_out   <= issue_s;
                issue_block_r <= issue_s;
            end
        end
    end

endmodule

// File: tb/tb_lsb_param.sv
// Scoreboard bench for lsb_param: expected issues are queued at stimulus time and checked by a monitor.
module tb_lsb_param;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int OW = 6;
    localparam int CN = 2;
    localparam int PW = 4;
    localparam logic [OW-1:0] OP_LB = 6'd10;
    localparam logic [OW-1:0] OP_LW = 6'd12;
    localparam logic [OW-1:0] OP_SW = 6'd17;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [DW-1:0] vj;
        logic [DW-1:0] vk;
        logic [DW-1:0] imm;
        logic [RW-1:0] rob;
    } issue_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic rdy_dp = 1'b0;
    logic [OW-1:0] op_dp = '0;
    logic [RW-1:0] qj_dp = '0, qk_dp = '0, rob_dp = '0, head_id = '0;
    logic [DW-1:0] vj_dp = '0, vk_dp = '0, a_dp = '0;
    logic full;
    logic [PW:0] count;
    logic idle = 1'b0;
    logic rdy_lsc;
    logic [OW-1:0] op_lsc;
    logic [DW-1:0] vj_lsc, vk_lsc, imm_lsc;
    logic [RW-1:0] rob_lsc;
    logic [CN-1:0] cdb_rdy = '0;
    logic [CN*DW-1:0] cdb_res = '0;
    logic [CN*RW-1:0] cdb_rob = '0;
    logic refresh = 1'b0;

    issue_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_issue = -10;

    lsb_param dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .rdy_dp_in(rdy_dp), .opcode_dp_in(op_dp), .qj_dp_in(qj_dp), .qk_dp_in(qk_dp),
        .vj_dp_in(vj_dp), .vk_dp_in(vk_dp), .A_dp_in(a_dp), .rob_id_dp_in(rob_dp),
        .lsb_full_dp_out(full), .lsb_count_out(count), .head_id_rob_in(head_id),
        .idle_lsc_in(idle), .rdy_lsc_out(rdy_lsc), .opcode_lsc_out(op_lsc),
        .vj_lsc_out(vj_lsc), .vk_lsc_out(vk_lsc), .imm_lsc_out(imm_lsc),
        .rob_id_lsc_out(rob_lsc), .cdb_rdy_in(cdb_rdy), .cdb_result_in(cdb_res),
        .cdb_rob_id_in(cdb_rob), .refresh_rob_cdb_in(refresh)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic monitor();
        issue_t got;
        issue_t want;
        forever begin
            @(negedge clk);
            if (rdy_lsc) begin
                got = {op_lsc, vj_lsc, vk_lsc, imm_lsc, rob_lsc};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue got rob %0d expected no issue", rob_lsc);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL issue_fields got %h expected %h", got, want);
                    end
                end
                checks++;
                if (cyc - last_issue < 2) begin
                    errors++;
                    $display("FAIL issue_gap got %0d expected >=2", cyc - last_issue);
                end
                last_issue = cyc;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [OW-1:0] op, input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                        input logic [DW-1:0] imm, input logic [RW-1:0] rob);
        issue_t e;
        e = {op, vj, vk, imm, rob};
        exp_q.push_back(e);
    endtask

    task automatic dispatch(input logic [OW-1:0] op, input logic [RW-1:0] qj, input logic [RW-1:0] qk,
                            input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                            input logic [DW-1:0] a, input logic [RW-1:0] rob);
        rdy_dp = 1'b1; op_dp = op; qj_dp = qj; qk_dp = qk;
        vj_dp = vj; vk_dp = vk; a_dp = a; rob_dp = rob;
        tick();
        rdy_dp = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && count == '0) break;
            tick();
        end
        tick();
        tick();
        chk({name, "_count"}, 32'(count), 32'd0);
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        tick();
        tick();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_rdy", 32'(rdy_lsc), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        rst = 1'b0;
        idle = 1'b1;

        // load issues the cycle after dispatch
        push(OP_LW, 32'h100, 32'h0, 32'h4, 5'd3);
        dispatch(OP_LW, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, 5'd3);
        chk("lw_count_after_dispatch", 32'(count), 32'd1);
        drain("lw", 10);

        // store waits for ROB head
        head_id = 5'd2;
        dispatch(OP_SW, 5'd0, 5'd0, 32'h200, 32'h1234, 32'h8, 5'd5);
        repeat (6) tick();
        chk("sw_held_count", 32'(count), 32'd1);
        head_id = 5'd5;
        push(OP_SW, 32'h200, 32'h1234, 32'h8, 5'd5);
        drain("sw", 10);

        // wakeup on both channels in one cycle
        dispatch(OP_LB, 5'd7, 5'd8, 32'h0, 32'h0, 32'h10, 5'd6);
        repeat (3) tick();
        chk("lb_waiting_count", 32'(count), 32'd1);
        cdb_rdy = 2'b11;
        cdb_rob = {5'd7, 5'd8};
        cdb_res = {32'hDEAD, 32'hBEEF};
        push(OP_LB, 32'hDEAD, 32'hBEEF, 32'h10, 5'd6);
        tick();
        cdb_rdy = 2'b00;
        drain("wakeup", 10);

        // global enable low freezes dispatch
        idle = 1'b0;
        rdy = 1'b0;
        dispatch(OP_LW, 5'd0, 5'd0, 32'h1, 32'h1, 32'h1, 5'd1);
        tick();
        rdy = 1'b1;
        chk("freeze_count", 32'(count), 32'd0);

        // fill to DEPTH, drop one, then drain with idle high
        head_id = 5'd0;
        for (int i = 1; i <= 16; i++) begin
            push(OP_LW, 32'(i * 16), 32'(i), 32'(i), 5'(i));
            dispatch(OP_LW, 5'd0, 5'd0, 32'(i * 16), 32'(i), 32'(i), 5'(i));
            if (i == 13) begin
                chk("fill13_count", 32'(count), 32'd13);
                chk("fill13_full", 32'(full), 32'd0);
            end
            if (i == 14) chk("fill14_full", 32'(full), 32'd1);
        end
        chk("fill16_count", 32'(count), 32'd16);
        chk("fill16_full", 32'(full), 32'd1);
        dispatch(OP_LW, 5'd0, 5'd0, 32'hBAD, 32'hBAD, 32'hBAD, 5'd20);
        chk("overflow_count", 32'(count), 32'd16);
        idle = 1'b1;
        drain("fill", 80);

        // flush with simultaneous dispatch
        idle = 1'b0;
        for (int i = 0; i < 5; i++) dispatch(OP_LW, 5'd0, 5'd0, 32'h40, 32'h0, 32'h0, 5'(i + 1));
        chk("preflush_count", 32'(count), 32'd5);
        refresh = 1'b1;
        dispatch(OP_LW, 5'd0, 5'd0, 32'h50, 32'h0, 32'h0, 5'd9);
        refresh = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_rdy", 32'(rdy_lsc), 32'd0);
        idle = 1'b1;
        repeat (5) tick();
        chk("postflush_count", 32'(count), 32'd0);

        // dispatch while its qk tag is on the CDB
        cdb_rdy = 2'b01;
        cdb_rob = {5'd0, 5'd9};
        cdb_res = {32'h0, 32'h55};
`ifdef LSB_DISPATCH_BYPASS_EN
        push(OP_LW, 32'h300, 32'h55, 32'h0, 5'd10);
`endif
        dispatch(OP_LW, 5'd0, 5'd9, 32'h300, 32'h0, 32'h0, 5'd10);
        cdb_rdy = 2'b00;
`ifdef LSB_DISPATCH_BYPASS_EN
        drain("bypass", 10);
`else
        repeat (10) tick();
        chk("stale_tag_count", 32'(count), 32'd1);
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        chk("stale_flush_count", 32'(count), 32'd0);
`endif
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
